sha256_block_feeder: RTL

//  Wrapper-side responder for the SHA-256 controller's message-load handshake.

---
 rtl/sha256_block_feeder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sha256_block_feeder.sv
// Message-block buffer and word streamer between the host register interface
// and the SHA-256 controller's wrapper_data request/valid handshake.
module sha256_block_feeder #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 16,
    parameter int VALID_GAP = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           host_wr_en,
    input  logic [$clog2(NUM_WORDS)-1:0]   host_wr_addr,
    input  logic [WORD_W-1:0]              host_wr_data,
    input  logic                           host_commit,
    input  logic                           err_clr,
    input  logic                           wrapper_data_request,
    output logic [WORD_W-1:0]              wrapper_data,
    output logic                           wrapper_data_valid,
    output logic                           block_ready,
    output logic                           busy,
    output logic [$clog2(NUM_WORDS+1)-1:0] words_sent,
    output logic                           done_pulse,
    output logic                           req_err,
    output logic                           wr_err
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int GAP_W = (VALID_GAP > 1) ? $clog2(VALID_GAP) : 1;
    localparam bit HAS_GAP = (VALID_GAP > 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((VALID_GAP > 0) ? (VALID_GAP - 1) : 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        STREAM = 3'd2,
        GAP    = 3'd3,
        PAUSE  = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [WORD_W-1:0]   words_r [NUM_WORDS];
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [GAP_W-1:0]    gap_r, gap_s;
    logic [WORD_W-1:0]   data_r, data_s;
    logic                valid_r, valid_s;
    logic                ready_r, ready_s;
    logic                busy_r, busy_s;
    logic [CNT_W-1:0]    sent_r, sent_s;
    logic                done_r, done_s;
    logic                req_err_r, req_err_s;
    logic                wr_err_r, wr_err_s;
    logic                buf_we_s;
    logic                new_req_err_s;
    logic                new_wr_err_s;

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        gap_s         = gap_r;
        data_s        = data_r;
        valid_s       = valid_r;
        ready_s       = ready_r;
        sent_s        = sent_r;
        done_s        = 1'b0;
        buf_we_s      = 1'b0;
        new_req_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                buf_we_s      = host_wr_en;
                new_req_err_s = wrapper_data_request;
                if (host_commit) begin
                    state_s = READY;
                    ready_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            READY: begin
                if (wrapper_data_request) begin
                    state_s = STREAM;
                    valid_s = 1'b1;
                    data_s  = words_r[0];
                    idx_s   = '0;
                    sent_s  = '0;
                end else begin
                    state_s = READY;
                end
            end
            STREAM: begin
                // valid is always high here, so request alone decides acceptance
                if (wrapper_data_request) begin
                    sent_s = sent_r + CNT_ONE;
                    if (idx_r == LAST_IDX) begin
                        valid_s = 1'b0;
                        ready_s = 1'b0;
                        state_s = DRAIN;
                    end else if (!HAS_GAP) begin
                        idx_s  = idx_r + IDX_ONE;
                        data_s = words_r[idx_r + IDX_ONE];
                    end else begin
                        valid_s = 1'b0;
                        idx_s   = idx_r + IDX_ONE;
                        gap_s   = GAP_LOAD;
                        state_s = GAP;
                    end
                end else begin
                    valid_s = 1'b0;
                    state_s = PAUSE;
                end
            end
            GAP: begin
                if (gap_r != '0) begin
                    gap_s = gap_r - GAP_ONE;
                end else if (wrapper_data_request) begin
                    valid_s = 1'b1;
                    data_s  = words_r[idx_r];
                    state_s = STREAM;
                end else begin
                    state_s = PAUSE;
                end
            end
            PAUSE: begin
                if (wrapper_data_request) begin
                    valid_s = 1'b1;
                    data_s  = words_r[idx_r];
                    state_s = STREAM;
                end else begin
                    state_s = PAUSE;
                end
            end
            DRAIN: begin
                if (!wrapper_data_request) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                ready_s = 1'b0;
            end
        endcase
        new_wr_err_s = (state_r != IDLE) && (host_wr_en || host_commit);
        // a fresh error outranks a simultaneous clear
        req_err_s    = new_req_err_s | (req_err_r & ~err_clr);
        wr_err_s     = new_wr_err_s | (wr_err_r & ~err_clr);
        busy_s       = (state_s == STREAM) || (state_s == GAP) ||
                       (state_s == PAUSE)  || (state_s == DRAIN);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            gap_r     <= '0;
            data_r    <= '0;
            valid_r   <= 1'b0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            sent_r    <= '0;
            done_r    <= 1'b0;
            req_err_r <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            gap_r     <= gap_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
            sent_r    <= sent_s;
            done_r    <= done_s;
            req_err_r <= req_err_s;
            wr_err_r  <= wr_err_s;
        end
    end

    // Message block storage, writable only while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                words_r[i] <= '0;
            end
        end else if (buf_we_s) begin
            words_r[host_wr_addr] <= host_wr_data;
        end
    end

    assign wrapper_data       = data_r;
    assign wrapper_data_valid = valid_r;
    assign block_ready        = ready_r;
    assign busy               = busy_r;
    assign words_sent         = sent_r;
    assign done_pulse         = done_r;
    assign req_err            = req_err_r;
    assign wr_err             = wr_err_r;

endmodule
